// File: rtl/uart_cmd_arb_pkg.sv
// Shared types and constants for the UART command arbiter.
// Holds the FSM state encoding, the read/write flag position and the WAIT_LOW limit.
package uart_cmd_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_DONE,
        WAIT_RD,
        RESP
    } state_t;

    // Cycles uart_cmd_rdy may stay high after issue before the command is given up as lost.
    localparam int WAIT_LOW_LIMIT = 4;

    function automatic int cmd_rw_bit(input int cmd_width);
        return cmd_width - 1;
    endfunction

endpackage

// File: rtl/uart_cmd_arb_if.sv
// Requester-side and UART-side signal bundle of the command arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface uart_cmd_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int CMD_WIDTH  = 16,
    parameter int READ_WIDTH = 8
);
    logic [NUM_REQ*CMD_WIDTH-1:0] req_cmd;
    logic [NUM_REQ-1:0]           req_vld;
    logic [NUM_REQ-1:0]           req_rdy;
    logic [NUM_REQ-1:0]           rsp_vld;
    logic [READ_WIDTH-1:0]        rsp_data;
    logic                         rsp_err;
    logic [CMD_WIDTH-1:0]         uart_cmd;
    logic                         uart_cmd_vld;
    logic                         uart_cmd_rdy;
    logic                         uart_read_rdy;
    logic [READ_WIDTH-1:0]        uart_read_data;

    modport master (
        output req_cmd, req_vld, uart_cmd_rdy, uart_read_rdy, uart_read_data,
        input  req_rdy, rsp_vld, rsp_data, rsp_err, uart_cmd, uart_cmd_vld
    );

    modport slave (
        input  req_cmd, req_vld, uart_cmd_rdy, uart_read_rdy, uart_read_data,
        output req_rdy, rsp_vld, rsp_data, rsp_err, uart_cmd, uart_cmd_vld
    );
endinterface

// File: rtl/uart_cmd_arb_rr_arbiter.sv
// Combinational round-robin winner selection: the first active request at or
// after ptr (wrapping) gets the one-hot grant.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    // NOTE: every variable written here gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_arb.sv
// Round-robin arbiter funnelling requester commands to one UART and routing read data back.
// Optional read timeout enabled by defining UART_CMD_ARB_TIMEOUT_EN.
module uart_cmd_arb
    import uart_cmd_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int CMD_WIDTH   = 16,
    parameter int READ_WIDTH  = 8,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_cmd_arb_if.slave  bus,
    output logic           busy
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int LOW_W  = $clog2(WAIT_LOW_LIMIT);
    localparam int RW_BIT = cmd_rw_bit(CMD_WIDTH);

    state_t                state, state_nxt;
    logic [PTR_W-1:0]      ptr, owner, grant_idx;
    logic [NUM_REQ-1:0]    grant;
    logic [CMD_WIDTH-1:0]  cmd_q;
    logic [READ_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q, is_read_q;
    logic [LOW_W-1:0]      low_cnt;
    logic                  accept, rd_capture, timeout_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (bus.req_vld),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) grant_idx = PTR_W'(i);
    end

    // Grant is suppressed while reset is held so req_rdy never pulses during reset.
    assign accept     = rst_n && (state == IDLE) && bus.uart_cmd_rdy && (|bus.req_vld);
    assign rd_capture = is_read_q && bus.uart_read_rdy &&
                        ((state == WAIT_DONE) || (state == WAIT_RD));

`ifdef UART_CMD_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    always_ff @(posedge clk) begin
        if (!rst_n || state != WAIT_RD) to_cnt <= '0;
        else                            to_cnt <= to_cnt + 1'b1;
    end

    assign timeout_hit = (state == WAIT_RD) && !bus.uart_read_rdy &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)           err_q <= 1'b0;
        else if (accept)      err_q <= 1'b0;
        else if (timeout_hit) err_q <= 1'b1;
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = ISSUE;
            ISSUE:     state_nxt = WAIT_LOW;
            WAIT_LOW: begin
                if (!bus.uart_cmd_rdy)                          state_nxt = WAIT_DONE;
                else if (low_cnt == LOW_W'(WAIT_LOW_LIMIT - 1)) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                // Data arriving in the same cycle as ready counts as already captured.
                if (bus.uart_cmd_rdy) begin
                    if (!is_read_q)                     state_nxt = IDLE;
                    else if (rd_valid_q || rd_capture) state_nxt = RESP;
                    else                                state_nxt = WAIT_RD;
                end
            end
            WAIT_RD:   if (rd_capture || timeout_hit) state_nxt = RESP;
            RESP:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            cmd_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            is_read_q  <= 1'b0;
            low_cnt    <= '0;
        end else begin
            state   <= state_nxt;
            low_cnt <= (state == WAIT_LOW) ? low_cnt + 1'b1 : '0;
            if (accept) begin
                cmd_q      <= bus.req_cmd[int'(grant_idx)*CMD_WIDTH +: CMD_WIDTH];
                is_read_q  <= bus.req_cmd[int'(grant_idx)*CMD_WIDTH + RW_BIT];
                owner      <= grant_idx;
                ptr        <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                rd_valid_q <= 1'b0;
            end
            if (rd_capture) begin
                rd_data_q  <= bus.uart_read_data;
                rd_valid_q <= 1'b1;
            end else if (timeout_hit) begin
                rd_data_q  <= '0;
            end
        end
    end

    assign bus.req_rdy      = accept ? grant : '0;
    assign bus.uart_cmd     = cmd_q;
    assign bus.uart_cmd_vld = (state == ISSUE);
    assign bus.rsp_vld      = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
    assign bus.rsp_data     = rd_data_q;
    assign busy             = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_arb.sv
// Randomized self-checking bench for uart_cmd_arb; a transaction-level model
// predicts grants, command issue, responses, lost commands and resets.
module tb_uart_cmd_arb;

    localparam int N  = 4;
    localparam int CW = 16;
    localparam int RW = 8;
`ifdef UART_CMD_ARB_TIMEOUT_EN
    localparam int TO    = 50;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 2000000;
    localparam bit TO_EN = 1'b0;
`endif

    typedef enum int {K_LOST, K_WRITE, K_RD_EARLY, K_RD_LATE, K_RD_TO, K_ABORT} kind_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    uart_cmd_arb_if #(.NUM_REQ(N), .CMD_WIDTH(CW), .READ_WIDTH(RW)) bus ();

    uart_cmd_arb #(
        .NUM_REQ(N), .CMD_WIDTH(CW), .READ_WIDTH(RW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rr_p    = 0;   // model round-robin pointer

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic noise();
        bus.uart_read_rdy  = 1'($urandom_range(0, 1));
        bus.uart_read_data = RW'($urandom);
    endtask

    task automatic quiet(input string tag);
        check(tag, {bus.uart_cmd_vld, bus.rsp_vld}, 0);
    endtask

    task automatic run_txn(input logic [N-1:0] vld, input kind_t kind,
                           input bit fixed, input logic [CW-1:0] fcmd, input logic [RW-1:0] frd);
        logic [CW-1:0] cmds [N];
        logic [CW-1:0] cmd;
        logic [RW-1:0] rd;
        logic          err;
        int            g, hold, early_slot, wcyc;
        @(negedge clk);
        for (int i = 0; i < N; i++) cmds[i] = CW'($urandom);
        g = rr_pick(vld, rr_p);
        if (kind == K_WRITE)                      cmds[g][CW-1] = 1'b0;
        else if (kind != K_LOST)                  cmds[g][CW-1] = 1'b1;
        rd = RW'($urandom);
        if (fixed) begin cmds[g] = fcmd; rd = frd; end
        cmd = cmds[g];
        err = 1'b0;
        for (int i = 0; i < N; i++) bus.req_cmd[i*CW +: CW] = cmds[i];
        bus.req_vld      = vld;
        bus.uart_cmd_rdy = 1'b1;
        noise();
        #1;
        check("grant", bus.req_rdy, 32'(1) << g);
        check("idle_busy", busy, 0);
        rr_p = (g + 1) % N;

        @(negedge clk);   // ISSUE
        bus.req_vld = '0;
        for (int i = 0; i < N; i++) bus.req_cmd[i*CW +: CW] = CW'($urandom);
        noise();
        #1;
        check("issue_vld", bus.uart_cmd_vld, 1);
        check("issue_cmd", bus.uart_cmd, cmd);
        check("issue_rdy", bus.req_rdy, 0);
        check("issue_busy", busy, 1);
        @(negedge clk);   // WAIT_LOW

        if (kind == K_LOST) begin
            for (int c = 0; c < 4; c++) begin
                noise(); #1; quiet("lost_quiet"); @(negedge clk);
            end
        end else begin
            hold = $urandom_range(0, 3);
            for (int c = 0; c < hold; c++) begin
                noise(); #1; quiet("wlow_quiet"); @(negedge clk);
            end
            bus.uart_cmd_rdy = 1'b0;
            noise(); #1; quiet("wlow_fall"); @(negedge clk);   // WAIT_DONE
            early_slot = $urandom_range(0, 1);
            for (int c = 0; c < 2; c++) begin
                if (kind == K_WRITE) noise();
                else begin
                    bus.uart_read_rdy  = (kind == K_RD_EARLY) && (c == early_slot);
                    bus.uart_read_data = bus.uart_read_rdy ? rd : RW'($urandom);
                end
                #1; quiet("wdone_quiet"); @(negedge clk);
            end
            bus.uart_cmd_rdy  = 1'b1;
            if (kind == K_WRITE) noise(); else bus.uart_read_rdy = 1'b0;
            #1; quiet("wdone_rise"); @(negedge clk);

            if (kind == K_ABORT) begin
                bus.uart_read_rdy = 1'b0;
                #1; quiet("abort_wrd"); check("abort_wrd_busy", busy, 1);
                @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                check("abort_rsp", bus.rsp_vld, 0);
                check("abort_busy", busy, 0);
                check("abort_cmd", bus.uart_cmd, 0);
                rst_n = 1'b1;
                rr_p  = 0;
                return;
            end

            if (kind == K_RD_LATE || kind == K_RD_TO) begin
                wcyc = (kind == K_RD_TO) ? TO : $urandom_range(0, 5);
                for (int c = 0; c < wcyc; c++) begin
                    bus.uart_read_rdy = 1'b0;
                    #1; quiet("wrd_quiet"); @(negedge clk);
                end
                if (kind == K_RD_TO) begin
                    rd  = '0;
                    err = 1'b1;
                end else begin
                    bus.uart_read_rdy  = 1'b1;
                    bus.uart_read_data = rd;
                    #1; quiet("wrd_cap"); @(negedge clk);
                end
            end

            if (kind != K_WRITE) begin   // RESP cycle
                noise();
                #1;
                check("rsp_vld", bus.rsp_vld, 32'(1) << g);
                check("rsp_data", bus.rsp_data, rd);
                check("rsp_err", bus.rsp_err, err);
                check("rsp_busy", busy, 1);
                @(negedge clk);
            end
        end

        bus.uart_read_rdy = 1'b0;
        #1;
        check("end_busy", busy, 0);
        check("end_rsp", bus.rsp_vld, 0);
        check("end_cmd_hold", bus.uart_cmd, cmd);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kind_t k;
        bus.req_cmd        = '1;
        bus.req_vld        = '1;
        bus.uart_cmd_rdy   = 1'b1;
        bus.uart_read_rdy  = 1'b1;
        bus.uart_read_data = '1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_rdy", bus.req_rdy, 0);
        check("rst_rsp_vld", bus.rsp_vld, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_uart_cmd", bus.uart_cmd, 0);
        check("rst_cmd_vld", bus.uart_cmd_vld, 0);
        check("rst_busy", busy, 0);
        bus.req_vld       = '0;
        bus.uart_read_rdy = 1'b0;
        rst_n = 1'b1;

        // Two requesters held, UART never dropping ready: 0, 2, 0 with lost commands.
        repeat (3) run_txn(4'b0101, K_LOST, 1'b0, '0, '0);
        run_txn(4'b0010, K_WRITE,    1'b1, 16'h1234, 8'h00);
        run_txn(4'b1000, K_RD_LATE,  1'b1, 16'h8055, 8'hA5);
        run_txn(4'b0110, K_RD_EARLY, 1'b0, '0, '0);
        if (TO_EN) run_txn(4'b1111, K_RD_TO, 1'b0, '0, '0);
        run_txn(4'b0100, K_ABORT,    1'b0, '0, '0);
        run_txn(4'b1111, K_WRITE,    1'b0, '0, '0);

        for (int t = 0; t < 200; t++) begin
            k = kind_t'($urandom_range(0, 5));
            if (k == K_RD_TO && (!TO_EN || ($urandom_range(0, 3) != 0))) k = K_RD_LATE;
            run_txn(N'($urandom_range(1, (1 << N) - 1)), k, 1'b0, '0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
